lsu_bus_master: RTL and testbench
=================================

// Module: lsu_bus_master
// PURPOSE
//  MEM-stage load/store initiator. Turns one pipeline memory op (sb/sh/sw, lb/lbu/lh/lhu/lw) into a
//  single word-aligned bus transaction with byte enables. Waits a variable number of cycles for the
//  data-memory responder's ack, and stalls the pipeline meanwhile. Returns sign/zero-extended load data.
//  Detects misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_W  8    width of the ack-wait counter
//  TIMEOUT    255  REQ cycles without bus_ack before abort (1..2^TIMEOUT_W-1)
// PORTS
//  clk           in   1   rising-edge clock
//  rst           in   1   asynchronous, active-high reset
//  req_valid     in   1   MEM stage holds a load/store
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   0=byte, 1=half, 3=word, 2=illegal
//  req_unsigned  in   1   1=zero-extend load (lbu/lhu)
//  req_addr      in   32  byte address (ALU result)
//  req_wdata     in   32  store data, right-justified
//  stall         out  1   freeze pipeline (combinational)
//  done          out  1   1-cycle pulse: op complete
//  rdata         out  32  extended load data, held until next load done
//  misalign      out  1   1-cycle pulse: illegal/misaligned op dropped
//  bus_err       out  1   1-cycle pulse with done: timeout abort
//  bus_req       out  1   request, held until bus_ack
//  bus_we        out  1   write strobe
//  bus_addr      out  32  {addr[31:2],2'b00}
//  bus_be        out  4   byte enables, bit i = byte lane i (little-endian)
//  bus_wdata     out  32  lane-replicated store data
//  bus_ack       in   1   responder accept/complete; bus_rdata valid same cycle
//  bus_rdata     in   32  full read word
// BEHAVIOUR
//  Reset (async): state=IDLE; every output = 0, including rdata. bus_req drops immediately;
//   an in-flight op is abandoned and not replayed.
//  FSM IDLE -> REQ -> DONE -> IDLE.
//  IDLE: if req_valid & legal, register we/size/unsigned/addr/wdata, stall=1, go to REQ.
//   If req_valid & illegal, misalign=1, stall=0, stay IDLE, no bus activity.
//   Illegal = size==2 | (size==1 & addr[0]) | (size==3 & addr[1:0]!=0).
//  REQ: bus_req=1, stall=1. Bus outputs come from registers and stay stable until ack.
//   Wait counter starts at 0 and increments each REQ cycle without ack.
//   On bus_ack: load -> capture extracted rdata; go to DONE.
//   Counter reaches TIMEOUT with no ack: drop bus_req, set err flag, go to DONE; rdata unchanged.
//  DONE: done=1, bus_err=err flag, stall=0 (pipeline advances); go to IDLE. req_valid ignored this cycle.
//  Latency: ack in first REQ cycle -> done 2 cycles after acceptance.
//   Back-to-back ops are accepted every 3 cycles.
//  bus_be: byte = 4'b0001<<addr[1:0]; half = addr[1]?4'b1100:4'b0011; word = 4'b1111.
//  bus_wdata: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
//   Loads drive be as above, with we=0, wdata=0.
//  Load extract: byte lane addr[1:0] / half lane addr[1].
//   Sign-extend from bit 7 (byte) or bit 15 (half) unless unsigned. Word passes through.
//  bus_ack while not in REQ is ignored. Stores never modify rdata.
//  bus_req, bus_we, bus_addr, bus_be and bus_wdata are 0 outside REQ.
// TESTING
//  1. sb addr=0x103, wdata=0x0000_00A5, ack on 1st REQ cycle
//     -> be=4'b1000, bus_addr=0x100, wdata=0xA5A5A5A5, done 2 cycles after accept.
//  2. lb addr=0x102, bus_rdata=0x1280_3456 -> rdata=0xFFFF_FF80;
//     same op as lbu -> rdata=0x0000_0080.
//  3. lh addr=0x2 rdata 0x8001_7FFF -> rdata=0xFFFF_8001;
//     lhu addr=0x0 -> 0x0000_7FFF; lw -> 0x8001_7FFF.
//  4. lw addr=0x6, sh addr=0x1, size=2
//     -> misalign pulse each, bus_req never asserts, stall=0, rdata unchanged.
//  5. TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then done=1 & bus_err=1, stall released.
//  6. rst pulsed mid-REQ (ack delayed 5 cycles)
//     -> bus_req/stall/rdata=0 asynchronously, FSM IDLE, late ack ignored.

Source files
------------

// File: rtl/lsu_bus_master_if.sv
// Word-aligned data-memory bus between the LSU initiator and its responder.
// The responder acks with read data valid in the same cycle.
interface lsu_bus_master_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: one pipeline op becomes one word-aligned bus
// transaction with byte enables, ack-wait timeout and load extension.
//
// state  | meaning
// IDLE   | waiting for a legal op; illegal ops pulse misalign and are dropped
// REQ    | bus_req held from registered op until ack or timeout
// DONE   | done pulse (bus_err on timeout), pipeline released
module lsu_bus_master #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    stall,
    output logic                    done,
    output logic [31:0]             rdata,
    output logic                    misalign,
    output logic                    bus_err,
    lsu_bus_master_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WAIT_TC = TIMEOUT_W'(TIMEOUT - 1);

    state_t               state, state_nxt;
    logic                 op_we, op_uns, err_q;
    logic [1:0]           op_size;
    logic [31:0]          op_addr, op_wdata;
    logic [3:0]           op_be;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 illegal, accept, tc_hit, in_req;
    logic [3:0]           be_c;
    logic [31:0]          wdata_c, load_c;
    logic [7:0]           lane_b;
    logic [15:0]          lane_h;

    assign illegal = (req_size == 2'd2)
                   | ((req_size == 2'd1) & req_addr[0])
                   | ((req_size == 2'd3) & (|req_addr[1:0]));
    assign tc_hit  = (wait_cnt == WAIT_TC);
    assign in_req  = (state == S_REQ);

    always_comb begin
        be_c    = 4'b0000;
        wdata_c = 32'h0;
        case (req_size)
            2'd0: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            2'd3: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
            default: ;
        endcase
        if (!req_we)
            wdata_c = 32'h0;
    end

    // Lane selection uses the registered address; the live request may already have moved on.
    always_comb begin
        case (op_addr[1:0])
            2'd0:    lane_b = bus.bus_rdata[7:0];
            2'd1:    lane_b = bus.bus_rdata[15:8];
            2'd2:    lane_b = bus.bus_rdata[23:16];
            default: lane_b = bus.bus_rdata[31:24];
        endcase
        lane_h = op_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (op_size)
            2'd0:    load_c = {{24{lane_b[7] & ~op_uns}}, lane_b};
            2'd1:    load_c = {{16{lane_h[15] & ~op_uns}}, lane_h};
            default: load_c = bus.bus_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        misalign  = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && !rst) begin
                    if (illegal) begin
                        misalign = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (bus.bus_ack || tc_hit)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign done          = (state == S_DONE);
    assign bus_err       = done & err_q;
    assign bus.bus_req   = in_req;
    assign bus.bus_we    = in_req & op_we;
    assign bus.bus_addr  = in_req ? {op_addr[31:2], 2'b00} : 32'h0;
    assign bus.bus_be    = in_req ? op_be : 4'b0000;
    assign bus.bus_wdata = in_req ? op_wdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_we    <= 1'b0;
            op_uns   <= 1'b0;
            op_size  <= 2'd0;
            op_addr  <= 32'h0;
            op_wdata <= 32'h0;
            op_be    <= 4'b0000;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            rdata    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_we    <= req_we;
                op_uns   <= req_unsigned;
                op_size  <= req_size;
                op_addr  <= req_addr;
                op_wdata <= wdata_c;
                op_be    <= be_c;
                wait_cnt <= '0;
                err_q    <= 1'b0;
            end else if (in_req) begin
                if (bus.bus_ack) begin
                    if (!op_we)
                        rdata <= load_c;
                end else if (tc_hit) begin
                    err_q <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + TIMEOUT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed vector table, reset-abort sequence and
// randomized ops checked against a transaction-level reference model.
module tb_lsu_bus_master;

    localparam int TO = 4;

    logic        clk, rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] rdata;

    lsu_bus_master_if bus_if();

    lsu_bus_master #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          delay;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_err;
        logic        exp_mis;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rdata_m;
    vec_t        vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(string nm, logic we, logic [1:0] size, logic uns,
                                logic [31:0] addr, logic [31:0] wdata, logic [31:0] rword,
                                int delay, logic [31:0] er, logic [3:0] eb,
                                logic [31:0] ew, logic ee, logic em);
        vec_t v;
        v.name = nm; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.rword = rword; v.delay = delay; v.exp_rdata = er;
        v.exp_be = eb; v.exp_wdata = ew; v.exp_err = ee; v.exp_mis = em;
        return v;
    endfunction

    // Reference model: plain arithmetic on byte offsets and widths.
    function automatic bit m_illegal(int size, logic [31:0] a);
        int off = int'(a % 32'd4);
        return (size == 2) || (size == 1 && off % 2 != 0) || (size == 3 && off != 0);
    endfunction

    function automatic logic [3:0] m_be(int size, logic [31:0] a);
        int off = int'(a % 32'd4);
        if (size == 0) return 4'(1 << off);
        if (size == 1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(int size, logic [31:0] w);
        if (size == 0) return (w % 32'h100) * 32'h0101_0101;
        if (size == 1) return (w % 32'h1_0000) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(int size, bit uns, logic [31:0] a, logic [31:0] w);
        longint v;
        longint span;
        if (size == 3) return w;
        span = (size == 0) ? 256 : 65536;
        v = longint'(w >> (8 * int'(a % 32'd4))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = v.addr & 32'hFFFF_FFFC;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; bus_if.bus_ack = 1'b0;
        #1;
        chk({v.name, " accept stall"}, 32'(stall), 32'(!v.exp_mis));
        chk({v.name, " misalign"}, 32'(misalign), 32'(v.exp_mis));
        chk({v.name, " idle bus_req"}, 32'(bus_if.bus_req), 32'd0);
        if (v.exp_mis) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk({v.name, " mis rdata"}, rdata, v.exp_rdata);
            chk({v.name, " mis bus_req"}, 32'(bus_if.bus_req), 32'd0);
            chk({v.name, " mis stall"}, 32'(stall), 32'd0);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
            bus_if.bus_ack   = (k == v.delay);
            bus_if.bus_rdata = bus_if.bus_ack ? v.rword : $urandom;
            #1;
            chk({v.name, " req bus_req"}, 32'(bus_if.bus_req), 32'd1);
            chk({v.name, " req stall"}, 32'(stall), 32'd1);
            chk({v.name, " req done"}, 32'(done), 32'd0);
            chk({v.name, " bus_we"}, 32'(bus_if.bus_we), 32'(v.we));
            chk({v.name, " bus_addr"}, bus_if.bus_addr, exp_addr);
            chk({v.name, " bus_be"}, 32'(bus_if.bus_be), 32'(v.exp_be));
            chk({v.name, " bus_wdata"}, bus_if.bus_wdata, v.exp_wdata);
            if (bus_if.bus_ack) break;
        end
        // DONE cycle: a new request and a stray ack here must both be ignored.
        @(negedge clk);
        bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
        req_valid = 1'b1; req_we = 1'($urandom % 2); req_size = 2'd3;
        req_addr = $urandom & 32'hFFFF_FFFC;
        #1;
        chk({v.name, " done"}, 32'(done), 32'd1);
        chk({v.name, " bus_err"}, 32'(bus_err), 32'(v.exp_err));
        chk({v.name, " done stall"}, 32'(stall), 32'd0);
        chk({v.name, " done bus_req"}, 32'(bus_if.bus_req), 32'd0);
        chk({v.name, " rdata"}, rdata, v.exp_rdata);
        @(negedge clk);
        req_valid = 1'b0; bus_if.bus_ack = 1'($urandom % 2); bus_if.bus_rdata = $urandom;
        #1;
        chk({v.name, " post done"}, 32'(done), 32'd0);
        chk({v.name, " post bus_err"}, 32'(bus_err), 32'd0);
        chk({v.name, " post bus_req"}, 32'(bus_if.bus_req), 32'd0);
        chk({v.name, " post stall"}, 32'(stall), 32'd0);
        chk({v.name, " post rdata"}, rdata, v.exp_rdata);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0]  = mk("sb_103",  1, 2'd0, 0, 32'h103, 32'hA5,        32'h0,         0,  32'h0000_0000, 4'b1000, 32'hA5A5_A5A5, 0, 0);
        vecs[1]  = mk("lb_102",  0, 2'd0, 0, 32'h102, 32'h0,         32'h1280_3456, 0,  32'hFFFF_FF80, 4'b0100, 32'h0,         0, 0);
        vecs[2]  = mk("lbu_102", 0, 2'd0, 1, 32'h102, 32'h0,         32'h1280_3456, 1,  32'h0000_0080, 4'b0100, 32'h0,         0, 0);
        vecs[3]  = mk("lh_2",    0, 2'd1, 0, 32'h2,   32'h0,         32'h8001_7FFF, 0,  32'hFFFF_8001, 4'b1100, 32'h0,         0, 0);
        vecs[4]  = mk("lhu_0",   0, 2'd1, 1, 32'h0,   32'h0,         32'h8001_7FFF, 2,  32'h0000_7FFF, 4'b0011, 32'h0,         0, 0);
        vecs[5]  = mk("lw_0",    0, 2'd3, 0, 32'h0,   32'h0,         32'h8001_7FFF, 0,  32'h8001_7FFF, 4'b1111, 32'h0,         0, 0);
        vecs[6]  = mk("lw_6",    0, 2'd3, 0, 32'h6,   32'h0,         32'h0,         0,  32'h8001_7FFF, 4'b0000, 32'h0,         0, 1);
        vecs[7]  = mk("sh_1",    1, 2'd1, 0, 32'h1,   32'h1234,      32'h0,         0,  32'h8001_7FFF, 4'b0000, 32'h0,         0, 1);
        vecs[8]  = mk("size2",   0, 2'd2, 0, 32'h100, 32'h0,         32'h0,         0,  32'h8001_7FFF, 4'b0000, 32'h0,         0, 1);
        vecs[9]  = mk("sw_200",  1, 2'd3, 0, 32'h200, 32'hDEAD_BEEF, 32'h0,         2,  32'h8001_7FFF, 4'b1111, 32'hDEAD_BEEF, 0, 0);
        vecs[10] = mk("sh_12",   1, 2'd1, 0, 32'h12,  32'h1234_ABCD, 32'h0,         1,  32'h8001_7FFF, 4'b1100, 32'hABCD_ABCD, 0, 0);
        vecs[11] = mk("lw_tmo",  0, 2'd3, 0, 32'h40,  32'h0,         32'h5555_5555, 10, 32'h8001_7FFF, 4'b1111, 32'h0,         1, 0);
        vecs[12] = mk("lb_last", 0, 2'd0, 0, 32'h1,   32'h0,         32'h0000_7F00, 3,  32'h0000_007F, 4'b0010, 32'h0,         0, 0);

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset rdata", rdata, 32'h0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        chk("reset misalign", 32'(misalign), 32'd0);
        chk("reset bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("reset bus_addr", bus_if.bus_addr, 32'h0);
        chk("reset bus_be", 32'(bus_if.bus_be), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            rdata_m = vecs[i].exp_rdata;
        end

        // Reset while a load waits for a late ack.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 32'h300; bus_if.bus_ack = 1'b0;
        #1;
        chk("rstreq accept stall", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("rstreq req1", 32'(bus_if.bus_req), 32'd1);
        @(negedge clk);
        #1;
        chk("rstreq req2", 32'(bus_if.bus_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq async bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rstreq async stall", 32'(stall), 32'd0);
        chk("rstreq async rdata", rdata, 32'h0);
        chk("rstreq async done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
            #1;
            chk("late ack bus_req", 32'(bus_if.bus_req), 32'd0);
            chk("late ack done", 32'(done), 32'd0);
            chk("late ack rdata", rdata, 32'h0);
        end
        bus_if.bus_ack = 1'b0;
        rdata_m = 32'h0;

        for (int n = 0; n < 150; n++) begin
            bit mis, err;
            v.name  = $sformatf("rand%0d", n);
            v.we    = 1'($urandom % 2);
            v.size  = 2'($urandom % 4);
            v.uns   = 1'($urandom % 2);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rword = $urandom;
            v.delay = int'($urandom_range(0, 5));
            mis = m_illegal(int'(v.size), v.addr);
            err = !mis && (v.delay >= TO);
            v.exp_mis   = mis;
            v.exp_err   = err;
            v.exp_be    = mis ? 4'h0 : m_be(int'(v.size), v.addr);
            v.exp_wdata = (mis || !v.we) ? 32'h0 : m_wdata(int'(v.size), v.wdata);
            v.exp_rdata = (!mis && !v.we && !err)
                        ? m_load(int'(v.size), v.uns, v.addr, v.rword) : rdata_m;
            run_vec(v);
            rdata_m = v.exp_rdata;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
